// File: rtl/ryuki_if_tracker_pkg.sv
// Shared datatypes for the ryuki stage trackers: timing records, the IF record
// that is handed downstream, and the fetch-tracker state encoding.
package ryuki_datatypes;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int TS_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [TS_WIDTH-1:0] time_start;
    logic [TS_WIDTH-1:0] time_end;
  } mem_access_t;

  // mem_access_req spans request..grant, mem_access_res spans grant+1..rvalid
  typedef struct packed {
    logic [TS_WIDTH-1:0] time_start;
    logic [TS_WIDTH-1:0] time_end;
    mem_access_t         mem_access_req;
    mem_access_t         mem_access_res;
  } IF_data;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instruction;
    logic [ADDR_WIDTH-1:0] addr;
    IF_data                if_data;
  } if_record;

endpackage

// File: rtl/ryuki_if_tracker_if.sv
// Bundle of the observed OBI fetch signals and the downstream trace handshake.
interface ryuki_if_tracker_if;
  import ryuki_datatypes::*;

  logic                  instr_req_i;
  logic                  instr_gnt_i;
  logic                  instr_rvalid_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic [DATA_WIDTH-1:0] instr_rdata_i;

  logic                  trace_valid_o;
  logic                  trace_ready_i;
  logic [DATA_WIDTH-1:0] trace_instr_o;
  logic [ADDR_WIDTH-1:0] trace_addr_o;
  IF_data                trace_if_o;
  logic                  overflow_o;

  modport master (
    output instr_req_i, instr_gnt_i, instr_rvalid_i, instr_addr_i, instr_rdata_i,
    output trace_ready_i,
    input  trace_valid_o, trace_instr_o, trace_addr_o, trace_if_o, overflow_o
  );

  modport slave (
    input  instr_req_i, instr_gnt_i, instr_rvalid_i, instr_addr_i, instr_rdata_i,
    input  trace_ready_i,
    output trace_valid_o, trace_instr_o, trace_addr_o, trace_if_o, overflow_o
  );

endinterface

// File: rtl/ryuki_if_tracker_trace_fifo.sv
// Generic record FIFO used by the stage trackers; head is read straight from
// storage, a push into a full FIFO is dropped unless a pop happens that cycle.
module ryuki_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             overflow_reg;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign valid     = (count_reg != '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign pop       = valid & pop_ready;
  assign wr_en     = push & (~full | pop);
  assign head_data = mem_reg[rd_ptr_reg];
  assign overflow  = overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (wr_en && !pop)      count_reg <= count_reg + CW'(1);
      else if (!wr_en && pop) count_reg <= count_reg - CW'(1);
      if (push && !wr_en) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/ryuki_if_tracker.sv
// Instruction-fetch stage tracker: observes one OBI fetch at a time, timestamps
// request/grant/response phases and queues completed records for the ID tracker.
module ryuki_if_tracker
  import ryuki_datatypes::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TS_WIDTH-1:0] counter,
  ryuki_if_tracker_if.slave   bus
);

  localparam int REC_W = $bits(if_record);

  if_state_e             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [TS_WIDTH-1:0]   time_start_reg;
  logic [TS_WIDTH-1:0]   req_start_reg;
  logic [TS_WIDTH-1:0]   req_end_reg;
  logic [TS_WIDTH-1:0]   res_start_reg;

  logic       start_fetch;
  logic       grant_now;
  logic       push;
  if_record   push_rec;
  logic [REC_W-1:0] head_data;
  if_record   head_rec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:
        if (bus.instr_req_i) state_next = bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
      WAIT_GNT:
        if (bus.instr_gnt_i) state_next = WAIT_RVALID;
      WAIT_RVALID:
        if (bus.instr_rvalid_i) begin
          if (bus.instr_req_i) state_next = bus.instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
          else                 state_next = IDLE;
        end
      default: state_next = IDLE;
    endcase
  end

  // A request arriving with rvalid restarts tracking in the same cycle
  always_comb begin
    start_fetch = 1'b0;
    grant_now   = 1'b0;
    push        = 1'b0;
    case (state_reg)
      IDLE: begin
        start_fetch = bus.instr_req_i;
        grant_now   = bus.instr_req_i & bus.instr_gnt_i;
      end
      WAIT_GNT: grant_now = bus.instr_gnt_i;
      WAIT_RVALID: begin
        push        = bus.instr_rvalid_i;
        start_fetch = bus.instr_rvalid_i & bus.instr_req_i;
        grant_now   = bus.instr_rvalid_i & bus.instr_req_i & bus.instr_gnt_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg       <= '0;
      time_start_reg <= '0;
      req_start_reg  <= '0;
      req_end_reg    <= '0;
      res_start_reg  <= '0;
    end else begin
      if (start_fetch) begin
        addr_reg       <= bus.instr_addr_i;
        time_start_reg <= counter;
        req_start_reg  <= counter;
      end
      if (grant_now) begin
        addr_reg      <= bus.instr_addr_i;
        req_end_reg   <= counter;
        res_start_reg <= counter + TS_WIDTH'(1);
      end
    end
  end

  always_comb begin
    push_rec                                   = '0;
    push_rec.instruction                       = bus.instr_rdata_i;
    push_rec.addr                              = addr_reg;
    push_rec.if_data.time_start                = time_start_reg;
    push_rec.if_data.time_end                  = counter;
    push_rec.if_data.mem_access_req.time_start = req_start_reg;
    push_rec.if_data.mem_access_req.time_end   = req_end_reg;
    push_rec.if_data.mem_access_res.time_start = res_start_reg;
    push_rec.if_data.mem_access_res.time_end   = counter;
  end

  ryuki_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rec),
    .pop_ready (bus.trace_ready_i),
    .valid     (bus.trace_valid_o),
    .head_data (head_data),
    .overflow  (bus.overflow_o)
  );

  assign head_rec          = head_data;
  assign bus.trace_instr_o = head_rec.instruction;
  assign bus.trace_addr_o  = head_rec.addr;
  assign bus.trace_if_o    = head_rec.if_data;

endmodule

// File: tb/tb_ryuki_if_tracker.sv
// Directed bench for ryuki_if_tracker: a transaction-level queue model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_ryuki_if_tracker;
  import ryuki_datatypes::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] counter;

  ryuki_if_tracker_if bus();

  ryuki_if_tracker #(.BUF_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .counter (counter),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       errors = 0;
  if_record model_q[$];
  logic     model_ovf;
  logic     exp_push;
  if_record exp_rec;
  logic     cmp_en;

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic if_record mk(input logic [31:0] d, input logic [31:0] a,
                                  input logic [31:0] ts, input logic [31:0] gc,
                                  input logic [31:0] te);
    if_record r;
    r.instruction                       = d;
    r.addr                              = a;
    r.if_data.time_start                = ts;
    r.if_data.time_end                  = te;
    r.if_data.mem_access_req.time_start = ts;
    r.if_data.mem_access_req.time_end   = gc;
    r.if_data.mem_access_res.time_start = gc + 32'd1;
    r.if_data.mem_access_res.time_end   = te;
    return r;
  endfunction

  // Transaction model: completions announced by the stimulus enter a bounded queue
  always @(posedge clk or negedge rst_n) begin : model
    bit popped;
    if (!rst_n) begin
      model_q.delete();
      model_ovf <= 1'b0;
    end else begin
      popped = (model_q.size() != 0) && bus.trace_ready_i;
      if (popped) void'(model_q.pop_front());
      if (exp_push) begin
        if (model_q.size() == DEPTH) model_ovf <= 1'b1;
        else                         model_q.push_back(exp_rec);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", {191'd0, bus.trace_valid_o}, {191'd0, model_q.size() != 0});
      chk("overflow", {191'd0, bus.overflow_o}, {191'd0, model_ovf});
      if (model_q.size() != 0) begin
        chk("head_instr", {160'd0, bus.trace_instr_o}, {160'd0, model_q[0].instruction});
        chk("head_addr", {160'd0, bus.trace_addr_o}, {160'd0, model_q[0].addr});
        chk("head_if", {64'd0, bus.trace_if_o}, {64'd0, model_q[0].if_data});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    counter  = counter + 32'd1;
    exp_push = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input int gw, input int rw, input int rv_rdy);
    logic [31:0] ts, gc;
    logic        keep;
    ts = counter;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = a;
    bus.instr_gnt_i  = (gw == 0);
    if (gw > 0) begin
      repeat (gw) cyc();
      bus.instr_gnt_i = 1'b1;
    end
    gc = counter;
    cyc();
    bus.instr_req_i = 1'b0;
    bus.instr_gnt_i = 1'b0;
    repeat (rw) cyc();
    bus.instr_rvalid_i = 1'b1;
    bus.instr_rdata_i  = d;
    keep = bus.trace_ready_i;
    if (rv_rdy >= 0) bus.trace_ready_i = rv_rdy[0];
    exp_rec  = mk(d, a, ts, gc, counter);
    exp_push = 1'b1;
    cyc();
    bus.instr_rvalid_i = 1'b0;
    bus.trace_ready_i  = keep;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, {191'd0, bus.trace_valid_o}, 192'd0);
    chk({name, "_ovf"}, {191'd0, bus.overflow_o}, 192'd0);
    chk({name, "_instr"}, {160'd0, bus.trace_instr_o}, 192'd0);
    chk({name, "_addr"}, {160'd0, bus.trace_addr_o}, 192'd0);
    chk({name, "_if"}, {64'd0, bus.trace_if_o}, 192'd0);
  endtask

  initial begin
    int n;
    counter = 0;
    exp_push = 1'b0;
    exp_rec = '0;
    cmp_en = 1'b0;
    bus.instr_req_i = 1'b0;
    bus.instr_gnt_i = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_addr_i = '0;
    bus.instr_rdata_i = '0;
    bus.trace_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    cyc();
    cyc();
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // req+gnt at 10, rvalid at 11, visible while counter reads 12
    counter = 10;
    fetch(32'h100, 32'hAAAA0001, 0, 0, -1);
    chk("s1_valid", {191'd0, bus.trace_valid_o}, 192'd1);
    chk("s1_if", {64'd0, bus.trace_if_o},
        {64'd0, 32'd10, 32'd11, 32'd10, 32'd10, 32'd11, 32'd11});
    bus.trace_ready_i = 1'b1;
    cyc();
    bus.trace_ready_i = 1'b0;

    // req 20, gnt 23, rvalid 26
    counter = 20;
    fetch(32'h80, 32'h00000013, 3, 2, -1);
    chk("s2_instr", {160'd0, bus.trace_instr_o}, 192'h13);
    chk("s2_addr", {160'd0, bus.trace_addr_o}, 192'h80);
    chk("s2_if", {64'd0, bus.trace_if_o},
        {64'd0, 32'd20, 32'd26, 32'd20, 32'd23, 32'd24, 32'd26});
    bus.trace_ready_i = 1'b1;
    cyc();
    bus.trace_ready_i = 1'b0;

    // back-to-back: rvalid of the first coincides with req+gnt of the second at 30
    counter = 29;
    bus.instr_req_i = 1'b1; bus.instr_gnt_i = 1'b1; bus.instr_addr_i = 32'h200;
    cyc();
    bus.instr_addr_i = 32'h204; bus.instr_rvalid_i = 1'b1; bus.instr_rdata_i = 32'hD1;
    exp_rec = mk(32'hD1, 32'h200, 29, 29, 30); exp_push = 1'b1;
    cyc();
    bus.instr_req_i = 1'b0; bus.instr_gnt_i = 1'b0; bus.instr_rdata_i = 32'hD2;
    exp_rec = mk(32'hD2, 32'h204, 30, 30, 31); exp_push = 1'b1;
    cyc();
    bus.instr_rvalid_i = 1'b0;
    chk("b2b_first_addr", {160'd0, bus.trace_addr_o}, 192'h200);
    bus.trace_ready_i = 1'b1;
    cyc();
    chk("b2b_second_addr", {160'd0, bus.trace_addr_o}, 192'h204);
    chk("b2b_second_if", {64'd0, bus.trace_if_o},
        {64'd0, 32'd30, 32'd31, 32'd30, 32'd30, 32'd31, 32'd31});
    cyc();
    bus.trace_ready_i = 1'b0;
    chk("b2b_drained", {191'd0, bus.trace_valid_o}, 192'd0);

    // three completions into a depth-2 buffer with no consumer
    for (int i = 0; i < 3; i++) fetch(32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 0, 1, -1);
    chk("ovf_set", {191'd0, bus.overflow_o}, 192'd1);
    chk("ovf_head", {160'd0, bus.trace_addr_o}, 192'h300);
    repeat (3) cyc();
    chk("ovf_sticky", {191'd0, bus.overflow_o}, 192'd1);

    // reset during WAIT_RVALID discards the fetch and clears everything at once
    bus.instr_req_i = 1'b1; bus.instr_gnt_i = 1'b1; bus.instr_addr_i = 32'h400;
    cyc();
    bus.instr_req_i = 1'b0; bus.instr_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1 chk_zero("midreset");
    cyc();
    rst_n = 1'b1;
    cyc();
    bus.instr_rvalid_i = 1'b1; bus.instr_rdata_i = 32'hDEAD;
    cyc();
    bus.instr_rvalid_i = 1'b0;
    cyc();
    chk("stale_rvalid", {191'd0, bus.trace_valid_o}, 192'd0);

    // full buffer with a pop in the same cycle as the push: nothing dropped
    fetch(32'h500, 32'hE0, 0, 0, -1);
    fetch(32'h504, 32'hE1, 0, 0, -1);
    fetch(32'h508, 32'hE2, 1, 0, 1);
    chk("full_pop_ovf", {191'd0, bus.overflow_o}, 192'd0);
    chk("full_pop_head", {160'd0, bus.trace_addr_o}, 192'h504);
    n = 0;
    bus.trace_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.trace_valid_o) n++;
      cyc();
    end
    bus.trace_ready_i = 1'b0;
    chk("full_pop_count", 192'(n), 192'd2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ryuki_if_tracker.md
RYUKI_IF_TRACKER -- requirements
Module: ryuki_if_tracker

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 2, number of completed-fetch records held for the downstream consumer (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port counter  input  32  free-running global cycle count, sampled as integer timestamp.
REQ-005 SHALL have port instr_req_i  input  1  core instruction-fetch request (observed only).
REQ-006 SHALL have port instr_gnt_i  input  1  memory grant (observed only).
REQ-007 SHALL have port instr_rvalid_i  input  1  memory read data valid (observed only).
REQ-008 SHALL have port instr_addr_i  input  ADDR_WIDTH  fetch address.
REQ-009 SHALL have port instr_rdata_i  input  DATA_WIDTH  fetched instruction word.
REQ-010 SHALL have port trace_valid_o  output  1  record available at buffer head.
REQ-011 SHALL have port trace_ready_i  input  1  consumer (ID tracker) accepts head record.
REQ-012 SHALL have port trace_instr_o  output  DATA_WIDTH  head record instruction.
REQ-013 SHALL have port trace_addr_o  output  ADDR_WIDTH  head record address.
REQ-014 SHALL have port trace_if_o  output  IF_data  head record stage timing.
REQ-015 SHALL have port overflow_o  output  1  sticky flag: a completed record was dropped.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID; one fetch tracked at a time (OBI single outstanding).
REQ-017 IDLE: on instr_req_i=1, SHALL latch addr, time_start=mem_access_req.time_start=counter; if instr_gnt_i=1 same cycle, mem_access_req.time_end=counter and go WAIT_RVALID, else go WAIT_GNT.
REQ-018 WAIT_GNT: on instr_gnt_i=1, SHALL set mem_access_req.time_end=counter, latch addr, go WAIT_RVALID; no timestamp change while waiting.
REQ-019 On entry to WAIT_RVALID, SHALL set mem_access_res.time_start=grant cycle counter+1.
REQ-020 WAIT_RVALID: on instr_rvalid_i=1, SHALL set mem_access_res.time_end=time_end=counter, capture instr_rdata_i, push record into buffer.
REQ-021 Same cycle as rvalid with instr_req_i=1, SHALL start next record per REQ-017 (zero-gap back-to-back fetch) without losing either.
REQ-022 instr_req_i/instr_gnt_i in WAIT_RVALID other than REQ-021 SHALL be ignored.
REQ-023 Buffer: FIFO, BUF_DEPTH entries, pointers wrap modulo BUF_DEPTH; trace_valid_o=not empty; pop on trace_valid_o&trace_ready_i; outputs show head combinationally from storage.
REQ-024 Push when full without simultaneous pop SHALL drop the new record, set overflow_o=1 until reset; full with simultaneous pop SHALL accept the push.
REQ-025 Push and pop same cycle when empty SHALL NOT bypass: record appears next cycle (latency rvalid->trace_valid_o = 1 cycle).
REQ-026 Timestamps SHALL be raw counter copies; counter wrap is not compensated.

Reset
REQ-027 rst_n=0 SHALL immediately force FSM=IDLE, buffer empty, trace_valid_o=0, overflow_o=0, all record fields 0; an in-flight fetch is discarded.
REQ-028 trace_instr_o, trace_addr_o, trace_if_o SHALL read 0 after reset until first push.

Structure
REQ-029 IF_data, mem_access_req, mem_access_res, and a new if_record struct (instruction, addr, IF_data) SHALL live in ryuki_datatypes; FSM state enum also there.
REQ-030 Buffer SHALL be sub-module ryuki_trace_fifo, parameterised on width and depth, reusable by later stage trackers.

Verification
REQ-031 req+gnt at counter=10, rvalid at 11 -> record time_start=10, req 10/10, res 11/11, time_end=11, valid at 12.
REQ-032 req at 20, gnt at 23, rvalid at 26, addr=0x80, rdata=0x00000013 -> req 20/23, res 24/26, start 20, end 26, instr/addr correct.
REQ-033 back-to-back: rvalid and new req+gnt both at 30, rvalid 31 -> two records, second start=30, end=31, order preserved.
REQ-034 trace_ready_i=0, BUF_DEPTH=2, three fetches complete -> first two held, third dropped, overflow_o=1 and stays 1.
REQ-035 full buffer, rvalid with trace_ready_i=1 same cycle -> no drop, overflow_o=0, count stays 2.
REQ-036 rst_n low in WAIT_RVALID -> outputs zero immediately; later rvalid without new req produces no record.
